mem_bus_controller: RTL and testbench



---
 rtl/mem_bus_controller.sv | 97 +++++++++
 tb/tb_mem_bus_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: sequences one CPU load/store/fetch at a time onto the 4 KB memory bus.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   cpu_req              request valid, sampled only while idle
//   cpu_we, cpu_ifetch   store select, instruction-fetch select (fetch wins over store)
//   cpu_addr, cpu_wdata  byte address and store data, latched at accept
//   cpu_rdata            load/fetch result, valid with cpu_ready
//   cpu_ready            one-cycle completion pulse
//   cpu_fault            00 ok, 01 misaligned, 10 store to instruction module, 11 fetch outside it
//   busy                 high while a request is in flight
//   address_bus          registered memory address
//   databus              bidirectional data, driven only while writing
//   write_mode           registered memory write enable
module mem_bus_controller #(
    parameter int READ_LATENCY = 1,
    parameter int WRITE_HOLD   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_ifetch,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [1:0]  cpu_fault,
    output logic        busy,
    output logic [11:0] address_bus,
    inout  wire  [15:0] databus,
    output logic        write_mode
);
    typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, DONE} state_t;

    localparam logic [2:0] RD_LAST = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WR_LAST = 3'(WRITE_HOLD - 1);

    state_t      state, state_n;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        oe;
    logic [2:0]  cnt;
    logic [1:0]  fault_n;
    logic        accept;

    // Misalignment outranks the region rules; a fetch ignores cpu_we.
    always_comb begin
        fault_n = cpu_addr[0] ? 2'b01 :
                  cpu_ifetch ? ((cpu_addr[11:10] != 2'b00) ? 2'b11 : 2'b00) :
                  (cpu_we && cpu_addr[11:10] == 2'b00) ? 2'b10 : 2'b00;
    end

    assign accept = (state == IDLE) && cpu_req;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cpu_req) state_n = (fault_n != 2'b00) ? DONE : SETUP;
            SETUP:   state_n = we_q ? WRITE : READ;
            WRITE:   if (cnt == WR_LAST) state_n = DONE;
            READ:    if (cnt == RD_LAST) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // write_mode and the bus enable come from the same next-state term so the
    // memory never sees a write strobe without data, and both drop on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            address_bus <= '0;
            write_mode  <= 1'b0;
            oe          <= 1'b0;
            cpu_rdata   <= '0;
            cpu_fault   <= 2'b00;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cnt         <= '0;
        end else begin
            state      <= state_n;
            cnt        <= ((state == WRITE || state == READ) && state_n == state) ? cnt + 3'd1 : 3'd0;
            write_mode <= (state_n == WRITE);
            oe         <= (state_n == WRITE);
            if (accept) begin
                cpu_fault <= fault_n;
                we_q      <= cpu_we & ~cpu_ifetch;
                wdata_q   <= cpu_wdata;
                if (fault_n == 2'b00) address_bus <= cpu_addr;
            end
            if (state == READ && state_n == DONE) cpu_rdata <= databus;
        end
    end

    assign databus   = oe ? wdata_q : 16'bz;
    assign cpu_ready = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: directed stimulus with a queue-based scoreboard and a memory model on the databus.
module tb_mem_bus_controller;
    localparam int RL = 3;
    localparam int WH = 2;

    typedef struct {
        logic [15:0] rd;
        logic [1:0]  f;
        int          lat;
        int          wm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_ifetch = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic [1:0]  cpu_fault;
    logic        busy;
    logic [11:0] address_bus;
    logic        write_mode;
    wire  [15:0] databus;

    logic [15:0] mem [2048] = '{default: 16'h0000};
    logic        pre_en = 1'b0;
    logic [10:0] pre_a = '0;
    logic [15:0] pre_d = '0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_ready = 0;
    int          wm_cnt = 0;
    int          base;
    logic        busy_d = 1'b0;
    logic [15:0] cur_wd = '0;
    logic [11:0] exp_abus = '0;
    exp_t        exp_q[$];
    int          acc_q[$];

    mem_bus_controller #(.READ_LATENCY(RL), .WRITE_HOLD(WH)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ifetch(cpu_ifetch),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_fault(cpu_fault), .busy(busy), .address_bus(address_bus), .databus(databus),
        .write_mode(write_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: returns the addressed word whenever it is not being written.
    assign databus = write_mode ? 16'bz : mem[address_bus[11:1]];
    always @(posedge clk) begin
        if (write_mode) mem[address_bus[11:1]] <= databus;
        else if (pre_en) mem[pre_a] <= pre_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] er, input logic [1:0] ef, input int lat, input int wm);
        exp_t e;
        e.rd = er; e.f = ef; e.lat = lat; e.wm = wm;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic ifetch, input logic [11:0] addr, input logic [15:0] wd,
                         input logic [15:0] er, input logic [1:0] ef, input int lat, input int wm);
        int n;
        push_exp(er, ef, lat, wm);
        cur_wd = wd;
        cpu_we = we; cpu_ifetch = ifetch; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!busy && n < 20);
        chk("accepted", {31'd0, busy}, 32'd1);
        if (ef == 2'b00) exp_abus = addr;
        cpu_req = 1'b0;
        cpu_addr = 12'($urandom); cpu_wdata = 16'($urandom);
        cpu_we = 1'($urandom); cpu_ifetch = 1'($urandom);
        n = 0;
        while (busy && n < 40) begin @(posedge clk); #1; n++; end
        chk("completed", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (busy && !busy_d) begin
            acc_q.push_back(cyc);
            wm_cnt = 0;
        end
        busy_d = busy;
        if (write_mode) begin
            wm_cnt++;
            chk("wr_data", {16'd0, databus}, {16'd0, cur_wd});
        end else begin
            chk("bus_release", {16'd0, databus}, {16'd0, mem[address_bus[11:1]]});
        end
        if (busy) chk("abus", {20'd0, address_bus}, {20'd0, exp_abus});
        if (cpu_ready) begin
            n_ready++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready pulse with nothing pending at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("fault", {30'd0, cpu_fault}, {30'd0, e.f});
                chk("rdata", {16'd0, cpu_rdata}, {16'd0, e.rd});
                chk("latency", 32'(cyc - a + 1), 32'(e.lat));
                chk("wm_cycles", 32'(wm_cnt), 32'(e.wm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        pre_en = 1'b1; pre_a = 11'h008; pre_d = 16'h1234;
        @(posedge clk); #1;
        pre_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_abus", {20'd0, address_bus}, 32'h0);
        chk("rst_wm", {31'd0, write_mode}, 32'h0);
        chk("rst_rdata", {16'd0, cpu_rdata}, 32'h0);
        chk("rst_ready", {31'd0, cpu_ready}, 32'h0);
        chk("rst_fault", {30'd0, cpu_fault}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;

        //     we    ifetch addr     wdata     exp_rd    fault  lat wm
        issue(1'b1, 1'b0, 12'h402, 16'hBEEF, 16'h0000, 2'b00, 4, 2);
        issue(1'b0, 1'b0, 12'h402, 16'h0000, 16'hBEEF, 2'b00, 5, 0);
        issue(1'b1, 1'b0, 12'h403, 16'hDEAD, 16'hBEEF, 2'b01, 1, 0);
        issue(1'b1, 1'b0, 12'h010, 16'hDEAD, 16'hBEEF, 2'b10, 1, 0);
        issue(1'b0, 1'b1, 12'h800, 16'h0000, 16'hBEEF, 2'b11, 1, 0);
        issue(1'b0, 1'b1, 12'h010, 16'h0000, 16'h1234, 2'b00, 5, 0);
        issue(1'b1, 1'b1, 12'h010, 16'hAAAA, 16'h1234, 2'b00, 5, 0);
        issue(1'b0, 1'b1, 12'h801, 16'h0000, 16'h1234, 2'b01, 1, 0);
        issue(1'b1, 1'b0, 12'hFFE, 16'h5A5A, 16'h1234, 2'b00, 4, 2);
        issue(1'b0, 1'b0, 12'hFFE, 16'h0000, 16'h5A5A, 2'b00, 5, 0);

        // cpu_req held across three completions must yield exactly three transactions.
        base = n_ready;
        for (int i = 0; i < 3; i++) push_exp(16'hBEEF, 2'b00, 5, 0);
        exp_abus = 12'h402;
        cpu_we = 1'b0; cpu_ifetch = 1'b0; cpu_addr = 12'h402; cpu_req = 1'b1;
        n = 0;
        while (n_ready < base + 3 && n < 100) begin @(negedge clk); #1; n++; end
        cpu_req = 1'b0;
        chk("held_three", 32'(n_ready), 32'(base + 3));
        repeat (12) @(negedge clk);
        #1;
        chk("held_no_extra", 32'(n_ready), 32'(base + 3));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write aborts it without a ready pulse.
        @(posedge clk); #1;
        cur_wd = 16'h1111;
        cpu_we = 1'b1; cpu_ifetch = 1'b0; cpu_addr = 12'h404; cpu_wdata = 16'h1111; cpu_req = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        exp_abus = 12'h404;
        n = 0;
        do begin @(negedge clk); n++; end while (!write_mode && n < 10);
        chk("wm_before_reset", {31'd0, write_mode}, 32'd1);
        #2;
        reset = 1'b1;
        exp_abus = 12'h000;
        #1;
        chk("reset_wm", {31'd0, write_mode}, 32'd0);
        chk("reset_bus", {16'd0, databus}, {16'd0, mem[0]});
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, cpu_ready}, 32'd0);
        base = n_ready;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc_q.delete();
        repeat (4) @(negedge clk);
        #1;
        chk("no_ready_after_reset", 32'(n_ready), 32'(base));
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 12'h402, 16'h0000, 16'hBEEF, 2'b00, 5, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
